// File: rtl/edp_regs.sv
// EBOX data path AR/ARX/MQ registers with source muxes and EBUS drive.
// Define EDP_AR_PARITY_EN to build the registered AR parity flag. Word bit 0 (MSB) is vector bit 35.
module edp_regs (
    input  logic        eboxClk,
    input  logic        eboxReset_n,
    input  logic [35:0] EDP_AD,
    input  logic [35:0] EDP_ADX,
    input  logic [35:0] EDP_SH,
    input  logic [35:0] CACHE_DATA,
    input  logic [35:0] EBUS_IN,
    input  logic        CTL_AR00to08load,
    input  logic        CTL_AR09to17load,
    input  logic        CTL_ARRload,
    input  logic        CTL_AR00to11clr,
    input  logic        CTL_AR12to17clr,
    input  logic        CTL_ARRclr,
    input  logic [2:0]  CTL_ARL_SEL,
    input  logic [2:0]  CTL_ARR_SEL,
    input  logic [2:0]  CTL_ARXL_SEL,
    input  logic [2:0]  CTL_ARXR_SEL,
    input  logic        CTL_ARX_LOAD,
    input  logic [1:0]  CTL_MQ_SEL,
    input  logic [1:0]  CTL_MQM_SEL,
    input  logic        CTL_MQM_EN,
    input  logic        CTL_adToEBUS_L,
    input  logic        CTL_adToEBUS_R,
    output logic [35:0] EDP_AR,
    output logic [35:0] EDP_ARX,
    output logic [35:0] EDP_MQ,
`ifdef EDP_AR_PARITY_EN
    output logic [35:0] EDP_EBUS_OUT,
    output logic        EDP_ARparity
`else
    output logic [35:0] EDP_EBUS_OUT
`endif
);

    logic [35:0] ad_x2, ad_q, adx_x2, adx_q;
    logic [17:0] arl, arr, arxl, arxr;
    logic [35:0] ar_next, arx_next, mq_next;

    // Shifted operands shared by the AR and ARX muxes
    assign ad_x2  = {EDP_AD[34:0], EDP_ADX[35]};
    assign ad_q   = {{2{EDP_AD[35]}}, EDP_AD[35:2]};
    assign adx_x2 = {EDP_ADX[34:0], EDP_MQ[35]};
    assign adx_q  = {EDP_AD[1:0], EDP_ADX[35:2]};

    always_comb begin
        arl = '0;
        case (CTL_ARL_SEL)
            3'd0: arl = CACHE_DATA[35:18];
            3'd1: arl = EDP_AD[35:18];
            3'd2: arl = EBUS_IN[35:18];
            3'd3: arl = EDP_SH[35:18];
            3'd4: arl = ad_x2[35:18];
            3'd5: arl = EDP_ADX[35:18];
            3'd6: arl = ad_q[35:18];
            default: arl = '0;
        endcase
    end

    always_comb begin
        arr = '0;
        case (CTL_ARR_SEL)
            3'd0: arr = CACHE_DATA[17:0];
            3'd1: arr = EDP_AD[17:0];
            3'd2: arr = EBUS_IN[17:0];
            3'd3: arr = EDP_SH[17:0];
            3'd4: arr = ad_x2[17:0];
            3'd5: arr = EDP_ADX[17:0];
            3'd6: arr = ad_q[17:0];
            default: arr = '0;
        endcase
    end

    always_comb begin
        arxl = '0;
        case (CTL_ARXL_SEL)
            3'd1: arxl = CACHE_DATA[35:18];
            3'd2: arxl = EDP_AD[35:18];
            3'd3: arxl = EDP_MQ[35:18];
            3'd4: arxl = EDP_SH[35:18];
            3'd5: arxl = adx_x2[35:18];
            3'd6: arxl = EDP_ADX[35:18];
            3'd7: arxl = adx_q[35:18];
            default: arxl = '0;
        endcase
    end

    always_comb begin
        arxr = '0;
        case (CTL_ARXR_SEL)
            3'd1: arxr = CACHE_DATA[17:0];
            3'd2: arxr = EDP_AD[17:0];
            3'd3: arxr = EDP_MQ[17:0];
            3'd4: arxr = EDP_SH[17:0];
            3'd5: arxr = adx_x2[17:0];
            3'd6: arxr = EDP_ADX[17:0];
            3'd7: arxr = adx_q[17:0];
            default: arxr = '0;
        endcase
    end

    // Clears are applied after loads so they win on overlapping bits
    always_comb begin
        ar_next = EDP_AR;
        if (CTL_AR00to08load) ar_next[35:27] = arl[17:9];
        if (CTL_AR09to17load) ar_next[26:18] = arl[8:0];
        if (CTL_ARRload)      ar_next[17:0]  = arr;
        if (CTL_AR00to11clr)  ar_next[35:24] = '0;
        if (CTL_AR12to17clr)  ar_next[23:18] = '0;
        if (CTL_ARRclr)       ar_next[17:0]  = '0;
    end

    assign arx_next = CTL_ARX_LOAD ? {arxl, arxr} : EDP_ARX;

    always_comb begin
        mq_next = EDP_MQ;
        if (CTL_MQM_EN) begin
            case (CTL_MQM_SEL)
                2'd0: mq_next = {EDP_ADX[1:0], EDP_MQ[35:2]};
                2'd1: mq_next = EDP_SH;
                2'd2: mq_next = EDP_AD;
                default: mq_next = '1;
            endcase
        end else begin
            case (CTL_MQ_SEL)
                2'd0: mq_next = EDP_MQ;
                2'd1: mq_next = EDP_SH;
                2'd2: mq_next = {EDP_MQ[34:0], 1'b0};
                default: mq_next = {EDP_ADX[0], EDP_MQ[35:1]};
            endcase
        end
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            EDP_AR  <= '0;
            EDP_ARX <= '0;
            EDP_MQ  <= '0;
        end else begin
            EDP_AR  <= ar_next;
            EDP_ARX <= arx_next;
            EDP_MQ  <= mq_next;
        end
    end

`ifdef EDP_AR_PARITY_EN
    logic ar_touch;

    assign ar_touch = CTL_AR00to08load | CTL_AR09to17load | CTL_ARRload |
                      CTL_AR00to11clr | CTL_AR12to17clr | CTL_ARRclr;

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n)  EDP_ARparity <= 1'b0;
        else if (ar_touch) EDP_ARparity <= ^ar_next;
    end
`endif

    assign EDP_EBUS_OUT = {CTL_adToEBUS_L ? EDP_AD[35:18] : 18'd0,
                           CTL_adToEBUS_R ? EDP_AD[17:0]  : 18'd0};

endmodule

// File: tb/tb_edp_regs.sv
// Self-checking bench for edp_regs: word-level model plus directed vectors.
// Word bit 0 (MSB) is vector bit 35; masks below use octal word notation.
module tb_edp_regs;

    localparam logic [35:0] M0_8  = 36'o777000_000000;
    localparam logic [35:0] M9_17 = 36'o000777_000000;
    localparam logic [35:0] C0_11 = 36'o777700_000000;
    localparam logic [35:0] C12_17 = 36'o000077_000000;
    localparam logic [35:0] RH    = 36'o000000_777777;
    localparam logic [35:0] LH    = 36'o777777_000000;

    logic eboxClk = 1'b0;
    logic eboxReset_n;
    logic [35:0] EDP_AD, EDP_ADX, EDP_SH, CACHE_DATA, EBUS_IN;
    logic CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload;
    logic CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr;
    logic [2:0] CTL_ARL_SEL, CTL_ARR_SEL, CTL_ARXL_SEL, CTL_ARXR_SEL;
    logic CTL_ARX_LOAD;
    logic [1:0] CTL_MQ_SEL, CTL_MQM_SEL;
    logic CTL_MQM_EN, CTL_adToEBUS_L, CTL_adToEBUS_R;
    logic [35:0] EDP_AR, EDP_ARX, EDP_MQ, EDP_EBUS_OUT;
`ifdef EDP_AR_PARITY_EN
    logic EDP_ARparity;
    logic m_par;
`endif

    logic [35:0] m_ar, m_arx, m_mq;
    logic [35:0] t_l, t_r, t_ar, t_arx, t_mq;
    int n_cmp = 0;
    int n_bad = 0;

    edp_regs dut (
        .eboxClk(eboxClk), .eboxReset_n(eboxReset_n),
        .EDP_AD(EDP_AD), .EDP_ADX(EDP_ADX), .EDP_SH(EDP_SH),
        .CACHE_DATA(CACHE_DATA), .EBUS_IN(EBUS_IN),
        .CTL_AR00to08load(CTL_AR00to08load),
        .CTL_AR09to17load(CTL_AR09to17load),
        .CTL_ARRload(CTL_ARRload),
        .CTL_AR00to11clr(CTL_AR00to11clr),
        .CTL_AR12to17clr(CTL_AR12to17clr),
        .CTL_ARRclr(CTL_ARRclr),
        .CTL_ARL_SEL(CTL_ARL_SEL), .CTL_ARR_SEL(CTL_ARR_SEL),
        .CTL_ARXL_SEL(CTL_ARXL_SEL), .CTL_ARXR_SEL(CTL_ARXR_SEL),
        .CTL_ARX_LOAD(CTL_ARX_LOAD),
        .CTL_MQ_SEL(CTL_MQ_SEL), .CTL_MQM_SEL(CTL_MQM_SEL),
        .CTL_MQM_EN(CTL_MQM_EN),
        .CTL_adToEBUS_L(CTL_adToEBUS_L), .CTL_adToEBUS_R(CTL_adToEBUS_R),
        .EDP_AR(EDP_AR), .EDP_ARX(EDP_ARX), .EDP_MQ(EDP_MQ),
`ifdef EDP_AR_PARITY_EN
        .EDP_EBUS_OUT(EDP_EBUS_OUT),
        .EDP_ARparity(EDP_ARparity)
`else
        .EDP_EBUS_OUT(EDP_EBUS_OUT)
`endif
    );

    always #5 eboxClk = ~eboxClk;

    task automatic chk(input string nm, input logic [35:0] act,
                       input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %012o want %012o at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] ar_src(input logic [2:0] sel);
        case (sel)
            3'd0: return CACHE_DATA;
            3'd1: return EDP_AD;
            3'd2: return EBUS_IN;
            3'd3: return EDP_SH;
            3'd4: return (EDP_AD << 1) | (EDP_ADX >> 35);
            3'd5: return EDP_ADX;
            3'd6: return 36'($signed(EDP_AD) >>> 2);
            default: return 36'd0;
        endcase
    endfunction

    function automatic logic [35:0] arx_src(input logic [2:0] sel);
        case (sel)
            3'd1: return CACHE_DATA;
            3'd2: return EDP_AD;
            3'd3: return m_mq;
            3'd4: return EDP_SH;
            3'd5: return (EDP_ADX << 1) | (m_mq >> 35);
            3'd6: return EDP_ADX;
            3'd7: return (EDP_ADX >> 2) | (EDP_AD << 34);
            default: return 36'd0;
        endcase
    endfunction

    function automatic logic [35:0] mq_src();
        if (CTL_MQM_EN) begin
            case (CTL_MQM_SEL)
                2'd0: return (m_mq >> 2) | (EDP_ADX << 34);
                2'd1: return EDP_SH;
                2'd2: return EDP_AD;
                default: return {36{1'b1}};
            endcase
        end
        case (CTL_MQ_SEL)
            2'd0: return m_mq;
            2'd1: return EDP_SH;
            2'd2: return m_mq << 1;
            default: return (m_mq >> 1) | (EDP_ADX << 35);
        endcase
    endfunction

    function automatic logic [35:0] ebus_exp();
        return (CTL_adToEBUS_L ? (EDP_AD & LH) : 36'd0) |
               (CTL_adToEBUS_R ? (EDP_AD & RH) : 36'd0);
    endfunction

    always @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            m_ar = '0;
            m_arx = '0;
            m_mq = '0;
`ifdef EDP_AR_PARITY_EN
            m_par = 1'b0;
`endif
        end else begin
            t_l = ar_src(CTL_ARL_SEL);
            t_r = ar_src(CTL_ARR_SEL);
            t_ar = m_ar;
            if (CTL_AR00to08load) t_ar = (t_ar & ~M0_8) | (t_l & M0_8);
            if (CTL_AR09to17load) t_ar = (t_ar & ~M9_17) | (t_l & M9_17);
            if (CTL_ARRload) t_ar = (t_ar & ~RH) | (t_r & RH);
            if (CTL_AR00to11clr) t_ar = t_ar & ~C0_11;
            if (CTL_AR12to17clr) t_ar = t_ar & ~C12_17;
            if (CTL_ARRclr) t_ar = t_ar & ~RH;
            t_arx = CTL_ARX_LOAD ?
                    ((arx_src(CTL_ARXL_SEL) & LH) | (arx_src(CTL_ARXR_SEL) & RH))
                    : m_arx;
            t_mq = mq_src();
`ifdef EDP_AR_PARITY_EN
            if (CTL_AR00to08load || CTL_AR09to17load || CTL_ARRload ||
                CTL_AR00to11clr || CTL_AR12to17clr || CTL_ARRclr)
                m_par = ^t_ar;
`endif
            m_ar = t_ar;
            m_arx = t_arx;
            m_mq = t_mq;
        end
    end

    always @(negedge eboxClk) begin
        chk("ar_model", EDP_AR, m_ar);
        chk("arx_model", EDP_ARX, m_arx);
        chk("mq_model", EDP_MQ, m_mq);
        chk("ebus_model", EDP_EBUS_OUT, ebus_exp());
`ifdef EDP_AR_PARITY_EN
        chk("par_model", {35'd0, EDP_ARparity}, {35'd0, m_par});
`endif
    end

    task automatic idle();
        {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload} = '0;
        {CTL_AR00to11clr, CTL_AR12to17clr, CTL_ARRclr} = '0;
        {CTL_ARL_SEL, CTL_ARR_SEL, CTL_ARXL_SEL, CTL_ARXR_SEL} = '0;
        CTL_ARX_LOAD = 1'b0;
        {CTL_MQ_SEL, CTL_MQM_SEL, CTL_MQM_EN} = '0;
        {CTL_adToEBUS_L, CTL_adToEBUS_R} = '0;
    endtask

    task automatic cyc();
        @(posedge eboxClk);
        @(negedge eboxClk);
        #1;
    endtask

    function automatic logic [35:0] r36();
        return {4'($urandom), $urandom};
    endfunction

    initial begin
        eboxReset_n = 1'b0;
        idle();
        {EDP_AD, EDP_ADX, EDP_SH, CACHE_DATA, EBUS_IN} = '0;
        @(negedge eboxClk);
        #1;
        chk("rst_ar", EDP_AR, 36'd0);
        chk("rst_arx", EDP_ARX, 36'd0);
        chk("rst_mq", EDP_MQ, 36'd0);
`ifdef EDP_AR_PARITY_EN
        chk("rst_par", {35'd0, EDP_ARparity}, 36'd0);
`endif
        eboxReset_n = 1'b1;
        cyc();

        // AD*2 into both halves: AD bit 35 shifts up, ADX bit 0 fills
        EDP_AD = 36'o400000_000001;
        EDP_ADX = 36'o400000_000000;
        CTL_ARL_SEL = 3'd4;
        CTL_ARR_SEL = 3'd4;
        {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload} = 3'b111;
        cyc();
        chk("ar_adx2", EDP_AR, 36'o000000_000003);

        idle();
        EDP_AD = '1;
        CTL_ARL_SEL = 3'd1;
        CTL_ARR_SEL = 3'd1;
        {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload} = 3'b111;
        CTL_AR00to11clr = 1'b1;
        cyc();
        chk("ar_clr0_11", EDP_AR, 36'o000077_777777);

        idle();
        EDP_SH = 36'o123456_701234;
        CTL_MQM_EN = 1'b1;
        CTL_MQM_SEL = 2'd1;
        cyc();
        chk("mq_sh", EDP_MQ, 36'o123456_701234);
        CTL_MQM_SEL = 2'd0;
        EDP_ADX = 36'o000000_000003;
        cyc();
        chk("mq_q", EDP_MQ, 36'o624713_560247);
        CTL_MQM_EN = 1'b0;
        CTL_MQ_SEL = 2'd0;
        cyc();
        chk("mq_hold", EDP_MQ, 36'o624713_560247);

        CTL_MQ_SEL = 2'd1;
        EDP_SH = 36'o111111_222222;
        cyc();
        idle();
        CTL_ARX_LOAD = 1'b1;
        CTL_ARXL_SEL = 3'd3;
        CTL_ARXR_SEL = 3'd0;
        CTL_adToEBUS_L = 1'b1;
        EDP_AD = '1;
        #1;
        chk("ebus_l", EDP_EBUS_OUT, 36'o777777_000000);
        cyc();
        chk("arx_mq", EDP_ARX, 36'o111111_000000);

        idle();
        CTL_ARL_SEL = 3'd7;
        CTL_ARR_SEL = 3'd7;
        {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload} = 3'b111;
        cyc();
        chk("ar_zero", EDP_AR, 36'd0);
        idle();
        CTL_ARL_SEL = 3'd1;
        CTL_AR09to17load = 1'b1;
        CTL_AR00to11clr = 1'b1;
        cyc();
        chk("ar_overlap", EDP_AR, 36'o000077_000000);

        // Reset pulse while a load is pending
        idle();
        CTL_AR00to08load = 1'b1;
        CTL_ARL_SEL = 3'd1;
        EDP_AD = 36'o777777_000000;
        eboxReset_n = 1'b0;
        #1;
        chk("rst_async", EDP_AR, 36'd0);
        cyc();
        chk("rst_hold", EDP_AR, 36'd0);
        eboxReset_n = 1'b1;
        cyc();
        chk("rst_release", EDP_AR, 36'o777000_000000);

`ifdef EDP_AR_PARITY_EN
        idle();
        CTL_ARL_SEL = 3'd7;
        CTL_ARR_SEL = 3'd1;
        EDP_AD = 36'o000000_000007;
        {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload} = 3'b111;
        cyc();
        chk("par_ar7", EDP_AR, 36'o000000_000007);
        chk("par_odd", {35'd0, EDP_ARparity}, 36'd1);
        idle();
        CTL_ARRclr = 1'b1;
        cyc();
        chk("par_clr", {35'd0, EDP_ARparity}, 36'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            EDP_AD = r36();
            EDP_ADX = r36();
            EDP_SH = r36();
            CACHE_DATA = r36();
            EBUS_IN = r36();
            {CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload} = 3'($urandom);
            CTL_AR00to11clr = ($urandom_range(7) == 0);
            CTL_AR12to17clr = ($urandom_range(7) == 0);
            CTL_ARRclr = ($urandom_range(7) == 0);
            CTL_ARL_SEL = 3'($urandom);
            CTL_ARR_SEL = 3'($urandom);
            CTL_ARXL_SEL = 3'($urandom);
            CTL_ARXR_SEL = 3'($urandom);
            CTL_ARX_LOAD = 1'($urandom);
            CTL_MQ_SEL = 2'($urandom);
            CTL_MQM_SEL = 2'($urandom);
            CTL_MQM_EN = 1'($urandom);
            CTL_adToEBUS_L = 1'($urandom);
            CTL_adToEBUS_R = 1'($urandom);
            if (i % 97 == 50) begin
                eboxReset_n = 1'b0;
                #2;
                eboxReset_n = 1'b1;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
